// File: rtl/bt_hdr_hec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : bt_hdr_hec_sequencer
// Purpose  : Bluetooth packet-header transmit controller. It latches a header
//            and UAP, seeds the external serial HEC-8 generator with the UAP,
//            feeds it the header bits, reads the HEC back, and emits the
//            header+HEC bit stream under a valid/ready handshake.
// Ports    : clk, reset (async, active-high)
//            start, header_in, uap        - request from the link controller
//            tx_ready / tx_valid, tx_bit,
//            tx_last                      - serial stream to the serializer
//            busy, done                   - sequence status
//            hec_clear, hec_valid,
//            hec_data, hec_uap, hec_value - HEC generator interface
//            hec_out                      - last captured HEC
// Options  : define HDR_FEC13_EN to send every bit three times (rate-1/3
//            repetition FEC, 54 transfers per header).
// Revision : 1.0 - initial release
// ============================================================================
module bt_hdr_hec_sequencer #(
  parameter int HDR_LEN = 10,
  parameter int HEC_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [HDR_LEN-1:0] header_in,
  input  logic [7:0]         uap,
  input  logic               tx_ready,
  output logic               tx_valid,
  output logic               tx_bit,
  output logic               tx_last,
  output logic               busy,
  output logic               done,
  output logic               hec_clear,
  output logic               hec_valid,
  output logic               hec_data,
  output logic [7:0]         hec_uap,
  input  logic [HEC_LEN-1:0] hec_value,
  output logic [HEC_LEN-1:0] hec_out
);

  localparam int HI_W = $clog2(HDR_LEN);
  localparam int HC_W = $clog2(HEC_LEN);

  localparam logic [4:0]      C_HDR_LAST = 5'(HDR_LEN - 1);
  localparam logic [4:0]      C_HEC_LAST = 5'(HEC_LEN - 1);
  localparam logic [HC_W-1:0] C_HEC_MSB  = HC_W'(HEC_LEN - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_CAP  = 3'd3;
  localparam logic [2:0] S_PAR  = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [HDR_LEN-1:0] hdr_q;
  logic [7:0]         uap_q;
  logic [HEC_LEN-1:0] hec_q;

  logic               w_in_hdr;
  logic               w_in_par;
  logic               w_xfer;
  logic               w_rep_last;
  logic               w_hdr_bit;
  logic               w_hec_bit;
  logic [HC_W-1:0]    w_hec_idx;

  assign w_in_hdr  = (state_q == S_HDR);
  assign w_in_par  = (state_q == S_PAR);
  assign w_xfer    = (w_in_hdr | w_in_par) & tx_ready;
  assign w_hdr_bit = hdr_q[cnt_q[HI_W-1:0]];
  // HEC leaves MSB first: parity bit j maps to hec_q[HEC_LEN-1-j].
  assign w_hec_idx = C_HEC_MSB - cnt_q[HC_W-1:0];
  assign w_hec_bit = hec_q[w_hec_idx];

`ifdef HDR_FEC13_EN
  // Repetition counter: each bit is held for three accepted transfers and
  // the bit counter only advances on the third one.
  logic [1:0] rep_q, rep_d;

  assign w_rep_last = (rep_q == 2'd2);

  always_comb begin
    rep_d = rep_q;
    if (!(w_in_hdr | w_in_par)) begin
      rep_d = 2'd0;
    end else if (tx_ready) begin
      rep_d = w_rep_last ? 2'd0 : (rep_q + 2'd1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rep_q <= 2'd0;
    end else begin
      rep_q <= rep_d;
    end
  end
`else
  assign w_rep_last = 1'b1;
`endif

  // Next-state logic; the bit counter restarts at 0 on every state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLR;
          cnt_d   = 5'd0;
        end
      end
      S_CLR: begin
        state_d = S_HDR;
        cnt_d   = 5'd0;
      end
      S_HDR: begin
        if (w_xfer && w_rep_last) begin
          if (cnt_q == C_HDR_LAST) begin
            state_d = S_CAP;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_CAP: begin
        state_d = S_PAR;
        cnt_d   = 5'd0;
      end
      S_PAR: begin
        if (w_xfer && w_rep_last) begin
          if (cnt_q == C_HEC_LAST) begin
            state_d = S_FIN;
            cnt_d   = 5'd0;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      hdr_q   <= '0;
      uap_q   <= 8'd0;
      hec_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == S_IDLE) && start) begin
        hdr_q <= header_in;
        uap_q <= uap;
      end
      // Generator has absorbed every header bit by the CAP cycle.
      if (state_q == S_CAP) begin
        hec_q <= hec_value;
      end
    end
  end

  // Outputs decode directly from registered state, so reset forces them low.
  always_comb begin
    tx_valid  = w_in_hdr | w_in_par;
    tx_bit    = 1'b0;
    tx_last   = 1'b0;
    hec_data  = 1'b0;
    hec_valid = 1'b0;
    if (w_in_hdr) begin
      tx_bit    = w_hdr_bit;
      hec_data  = w_hdr_bit;
      // Only one shift per header bit, on its final accepted transfer.
      hec_valid = tx_ready & w_rep_last;
    end
    if (w_in_par) begin
      tx_bit  = w_hec_bit;
      tx_last = (cnt_q == C_HEC_LAST) & w_rep_last;
    end
  end

  assign busy      = (state_q == S_CLR) | w_in_hdr | (state_q == S_CAP) | w_in_par;
  assign done      = (state_q == S_FIN);
  assign hec_clear = (state_q == S_CLR);
  assign hec_uap   = uap_q;
  assign hec_out   = hec_q;

endmodule
`default_nettype wire

// File: tb/tb_bt_hdr_hec_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bt_hdr_hec_sequencer
// Purpose  : Scoreboard bench for bt_hdr_hec_sequencer with a behavioural
//            serial HEC-8 generator (g(D) = D^8+D^7+D^5+D^2+D+1).
// Options  : honours HDR_FEC13_EN (bit repetition x3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_bt_hdr_hec_sequencer;

`ifdef HDR_FEC13_EN
  localparam int REP = 3;
`else
  localparam int REP = 1;
`endif
  localparam int NXFER = 18 * REP;
  localparam int LAT   = NXFER + 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] header_in = '0;
  logic [7:0] uap = '0;
  logic       tx_ready = 1'b1;
  logic       tx_valid, tx_bit, tx_last, busy, done;
  logic       hec_clear, hec_valid, hec_data;
  logic [7:0] hec_uap, hec_value, hec_out;

  bt_hdr_hec_sequencer #(.HDR_LEN(10), .HEC_LEN(8)) dut (
    .clk(clk), .reset(reset), .start(start), .header_in(header_in), .uap(uap),
    .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_last(tx_last),
    .busy(busy), .done(done), .hec_clear(hec_clear), .hec_valid(hec_valid),
    .hec_data(hec_data), .hec_uap(hec_uap), .hec_value(hec_value), .hec_out(hec_out)
  );

  always #5 clk = ~clk;

  // Serial HEC generator, active-low reset.
  logic       gen_rst_n;
  logic [7:0] gen_r;
  assign gen_rst_n = ~reset;
  always @(posedge clk or negedge gen_rst_n) begin
    if (!gen_rst_n)     gen_r <= 8'h00;
    else if (hec_clear) gen_r <= hec_uap;
    else if (hec_valid) gen_r <= {gen_r[6:0], 1'b0} ^ (((hec_data ^ gen_r[7]) != 1'b0) ? 8'hA7 : 8'h00);
  end
  assign hec_value = gen_r;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] hec_model(input logic [9:0] h, input logic [7:0] u);
    logic [7:0] r;
    logic       fb;
    r = u;
    for (int i = 0; i < 10; i++) begin
      fb = h[i] ^ r[7];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'hA7;
    end
    return r;
  endfunction

  typedef struct packed { logic b; logic l; } exp_t;
  exp_t       exp_q[$];
  logic [7:0] exp_hec_q[$];

  function automatic void push_pkt(input logic [9:0] h, input logic [7:0] hec);
    int idx;
    exp_t e;
    idx = 0;
    for (int i = 0; i < 10; i++)
      for (int r = 0; r < REP; r++) begin
        e.b = h[i]; e.l = (idx == NXFER - 1); exp_q.push_back(e); idx++;
      end
    for (int j = 7; j >= 0; j--)
      for (int r = 0; r < REP; r++) begin
        e.b = hec[j]; e.l = (idx == NXFER - 1); exp_q.push_back(e); idx++;
      end
    exp_hec_q.push_back(hec);
  endfunction

  // tx_ready driver: 0 = tied high, 1 = random, 2 = scripted stalls
  int rdy_mode = 0;
  int stall_left = 0;
  int pkt_xfer = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1: tx_ready = ($urandom_range(0, 3) != 0);
      2: begin
        if (stall_left > 0) begin tx_ready = 1'b0; stall_left--; end
        else tx_ready = 1'b1;
      end
      default: tx_ready = 1'b1;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer and on every done pulse.
  logic prev_stall = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] eh;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (!tx_valid) chk("idle_bit_last", {30'd0, tx_bit, tx_last}, 32'd0);
      if (prev_stall) chk("valid_held", {31'd0, tx_valid}, 32'd1);
      prev_stall = tx_valid && !tx_ready;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_xfer", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("bit%0d", pkt_xfer), {30'd0, tx_bit, tx_last}, {30'd0, e.b, e.l});
        end
        if (rdy_mode == 2 && (pkt_xfer == 4 || pkt_xfer == 12))
          stall_left = (pkt_xfer == 4) ? 3 : 2;
        pkt_xfer++;
      end
      if (done) begin
        if (exp_hec_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          eh = exp_hec_q.pop_front();
          chk("hec_out", {24'd0, hec_out}, {24'd0, eh});
        end
      end
    end
  end

  task automatic run_pkt(input logic [9:0] h, input logic [7:0] u, input logic [7:0] hec,
                         input int exp_lat, input bit noise, input bit fin_poke);
    int  t0;
    int  n;
    bit  got;
    @(posedge clk); #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    pkt_xfer  = 0;
    header_in = h;
    uap       = u;
    start     = 1'b1;
    t0        = cyc;
    push_pkt(h, hec);
    @(posedge clk); #1;
    start     = 1'b0;
    header_in = 10'($urandom);
    uap       = 8'($urandom);
    got = 0;
    n   = 0;
    while (!got && n < 3000) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        @(posedge clk); #1;
        if (noise && busy && $urandom_range(0, 5) == 0) begin
          start     = 1'b1;
          header_in = 10'($urandom);
          uap       = 8'($urandom);
        end else begin
          start = 1'b0;
        end
        n++;
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 32'd1, 32'd0);
    else if (exp_lat >= 0) chk("done_latency", 32'(cyc - t0), 32'(exp_lat));
    chk("hec_value_model", {24'd0, hec_out}, {24'd0, hec_model(h, u)});
    if (fin_poke) begin
      start = 1'b1;          // lands in the FIN cycle, must be ignored
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("fin_start_ignored", {30'd0, busy, tx_valid}, 32'd0);
    end
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    logic [9:0] h;
    logic [7:0] u;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", {22'd0, tx_valid, tx_bit, tx_last, busy, done, hec_clear, hec_valid, hec_data, 2'b00},
        32'd0);
    chk("reset_hec", {16'd0, hec_uap, hec_out}, 32'd0);
    reset = 1'b0;

    // Test 1: all zero
    rdy_mode = 0;
    run_pkt(10'h000, 8'h00, 8'h00, LAT, 1'b0, 1'b1);
    chk("t1_hec_out", {24'd0, hec_out}, 32'h00);

    // Test 2: header 0x001, UAP 0x00 -> HEC 0x16 (bits 0,0,0,1,0,1,1,0)
    run_pkt(10'h001, 8'h00, 8'h16, LAT, 1'b0, 1'b0);
    chk("t2_hec_out", {24'd0, hec_out}, 32'h16);
    chk("t2_hec_uap", {24'd0, hec_uap}, 32'h00);

    // Test 3: stalls of 3 and 2 cycles delay done by 5
    rdy_mode = 2;
    run_pkt(10'h001, 8'h00, 8'h16, LAT + 5, 1'b0, 1'b0);
    chk("t3_hec_out", {24'd0, hec_out}, 32'h16);

    // Test 4: random packets, random ready, start pokes while busy
    rdy_mode = 1;
    for (int p = 0; p < 200; p++) begin
      h = 10'($urandom);
      u = 8'($urandom);
      run_pkt(h, u, hec_model(h, u), -1, 1'b1, 1'b0);
    end
    chk("t4_hec_uap_held", {24'd0, hec_uap}, {24'd0, u});

    // Test 5: reset in the middle of the header
    rdy_mode = 0;
    @(posedge clk); #1;
    pkt_xfer  = 0;
    header_in = 10'h2AA;
    uap       = 8'h5A;
    start     = 1'b1;
    push_pkt(10'h2AA, hec_model(10'h2AA, 8'h5A));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("pre_reset_busy", {30'd0, busy, tx_valid}, 32'd3);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_outputs", {22'd0, tx_valid, tx_bit, tx_last, busy, done, hec_clear, hec_valid, hec_data, 2'b00},
        32'd0);
    chk("abort_hec", {16'd0, hec_uap, hec_out}, 32'd0);
    exp_q.delete();
    exp_hec_q.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("post_reset_done", {31'd0, done}, 32'd0);
    run_pkt(10'h001, 8'h00, 8'h16, LAT, 1'b0, 1'b0);
    chk("t5_hec_out", {24'd0, hec_out}, 32'h16);

`ifdef HDR_FEC13_EN
    // Test 6: tripled stream, 54 transfers
    run_pkt(10'h001, 8'h00, 8'h16, 57, 1'b0, 1'b0);
    chk("t6_xfers", 32'(pkt_xfer), 32'd54);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bt_hdr_hec_sequencer.md
Name: bt_hdr_hec_sequencer

Overview:
- Packet-header transmit controller for the Bluetooth PHY.
- Accepts a 10-bit header (LT_ADDR, TYPE, FLOW, ARQN, SEQN) plus UAP. Sequences the serial HEC-8 generator: clears and seeds it with the UAP, feeds it the header bits, then reads back the HEC.
- Emits the 18-bit header+HEC stream serially to the downstream bit pipe under a valid/ready handshake.
- Sits between the link controller and the packet serializer.

Parameters:
- HDR_LEN, 10, header bits shifted through the HEC generator.
- HEC_LEN, 8, HEC width read back from the generator.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request to send one header; sampled only while busy=0.
- header_in  input  HDR_LEN  header, bit 0 transmitted first; latched on accepted start.
- uap  input  8  UAP seed; latched on accepted start.
- tx_ready  input  1  downstream accepts tx_bit this cycle.
- tx_valid  output  1  tx_bit is valid.
- tx_bit  output  1  serial header/HEC bit.
- tx_last  output  1  marks the final transfer of the header.
- busy  output  1  sequence in progress.
- done  output  1  one-cycle pulse after the final transfer.
- hec_clear  output  1  to HEC generator clear_reg.
- hec_valid  output  1  to HEC generator valid_in.
- hec_data  output  1  to HEC generator data_in.
- hec_uap  output  8  to HEC generator uap_dci; the latched UAP.
- hec_value  input  HEC_LEN  from HEC generator hec_reg.
- hec_out  output  HEC_LEN  captured HEC of the last header, held until the next capture.

Behaviour:
- Reset: all outputs 0, hec_out=0, latches cleared, state IDLE. Reset mid-sequence aborts immediately; no done pulse.
- States: IDLE, CLR, HDR, CAP, PAR, FIN.
- IDLE:
  - busy=0. start=1 latches header_in and uap, then goes to CLR.
  - start while busy=1 is ignored.
- CLR (1 cycle):
  - hec_clear=1, hec_valid=0, hec_uap=latched UAP.
  - Then HDR with bit index k=0.
- HDR:
  - tx_valid=1, tx_bit=hdr[k], hec_data=hdr[k], hec_valid=tx_ready.
  - The HEC generator shifts only on accepted transfers. Stall cycles hold hec_valid=0 and hec_clear=0; the generator tolerates gaps.
  - On a transfer with k=HDR_LEN-1, go to CAP.
- CAP (1 cycle):
  - tx_valid=0. hec_value is final.
  - Capture into hec_q and hec_out, then go to PAR with j=0.
- PAR:
  - tx_valid=1, tx_bit=hec_q[HEC_LEN-1-j], i.e. MSB (hec_reg[7]) first.
  - tx_last=1 when j=HEC_LEN-1.
  - On a transfer at the last bit, go to FIN.
- FIN (1 cycle):
  - done=1, busy=0, then IDLE.
  - A start in the FIN cycle is ignored; a start in the following cycle is accepted.
- busy=1 in CLR, HDR, CAP, PAR.
- hec_uap holds the latched UAP from the CLR cycle until the next accepted start.
- tx_bit is 0 whenever tx_valid=0. tx_valid, once raised, is never dropped without a transfer.
- Latency with tx_ready tied high: start sampled at edge 0 → first bit in cycle 2, last bit in cycle 20, done in cycle 21. A new start is accepted no earlier than cycle 22.
- Bit counter: 5 bits, saturates never, reset to 0 on each state entry.

Optional Feature:
- HDR_FEC13_EN defined: each of the 18 bits is sent three consecutive times (rate-1/3 repetition FEC); 54 transfers total.
  - hec_valid is asserted only on the third accepted repetition of each header bit.
  - tx_last is set on the 54th transfer.
  - With tx_ready tied high, done lands in cycle 57.
- HDR_FEC13_EN undefined: 18 transfers as above; repetition counter not instantiated.

Test Plan:
- The bench instantiates the HEC generator with its reset tied to ~reset.
- Test 1: uap=0x00, header_in=0x000, tx_ready=1 → 18 zero bits, tx_last on the 18th, hec_out=0x00, done in cycle 21.
- Test 2: uap=0x00, header_in=0x001, tx_ready=1 → bits 1,0×9 then HEC bits 0,0,0,1,0,1,1,0; hec_out=0x16.
- Test 3: same as test 2 with tx_ready low for 3 cycles after bit 4 and 2 cycles during HEC bit 3 → identical bit stream, hec_out=0x16, tx_valid held through stalls, done delayed by 5 cycles.
- Test 4: random header/UAP, 200 packets, random tx_ready → stream and hec_out match a software HEC model. Start pulses while busy are ignored.
- Test 5: reset asserted during HDR k=6 → all outputs 0 next cycle, no done. A new start with uap=0x00/header=0x001 gives hec_out=0x16, proving a clean reseed.
- Test 6 (HDR_FEC13_EN): uap=0x00, header=0x001 → 1,1,1 then 27 zeros, then each HEC bit tripled. 54 transfers, hec_out=0x16.
